debug_dump_tx: RTL and testbench

Streams a snapshot of MIPS processor state out of the core for the debug host. It is the outbound counterpart of the instruction-loading path, which pushes words in through `INSTRUCTION_IN`/`FLAG_I`. On a start request it halts the pipeline, then walks the register file and data memory. It emits a framed word stream with a valid/ready handshake and closes the frame with an XOR checksum. It sits between the TP4 core's debug read ports and the host-link transmitter.

---
 rtl/debug_dump_tx_pkg.sv | 26 ++
 rtl/debug_dump_tx.sv | 148 ++++++++++++++
 tb/tb_debug_dump_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_dump_tx_pkg.sv
// rtl/debug_dump_tx_pkg.sv - shared MIPS debug dump types and frame constants
package debug_dump_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PCW,
    S_REGS,
    S_MEM,
    S_CSUM
  } state_e;

  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hD0D0;
  localparam int          NUM_REGS        = 32;

  // header + PC + register file + data memory + checksum
  function automatic int frame_words(input int dm_words);
    return 3 + NUM_REGS + dm_words;
  endfunction

  // a single-word memory still gets a 1-bit address port
  function automatic int dm_addr_w(input int dm_words);
    return (dm_words > 1) ? $clog2(dm_words) : 1;
  endfunction

endpackage

// File: rtl/debug_dump_tx.sv
// rtl/debug_dump_tx.sv - halts the core and streams PC, register file and data memory as a checksummed frame
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int          DM_WORDS = 32,
  parameter logic [15:0] HDR_TAG  = HDR_TAG_DEFAULT,
  localparam int         AW       = dm_addr_w(DM_WORDS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          DUMP_START,
  input  logic [31:0]   PC_IN,
  output logic [4:0]    RF_ADDR,
  input  logic [31:0]   RF_DATA,
  output logic [AW-1:0] DM_ADDR,
  input  logic [31:0]   DM_DATA,
  output logic          HALT_REQ,
  output logic          BUSY,
  output logic [31:0]   DOUT,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic          DOUT_LAST
);

  localparam int IW = (AW > 5) ? AW : 5;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [31:0]   csum_q, csum_d;
  logic [31:0]   pc_q, pc_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          xfer;

  assign xfer = valid_q && DOUT_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      csum_q      <= '0;
      pc_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      csum_q      <= csum_d;
      pc_q        <= pc_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The word after the current one is loaded on the transfer edge, so the
  // debug read ports always look one index ahead.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    last_d      = last_q;
    csum_d      = csum_q;
    pc_d        = pc_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (DUMP_START) begin
          state_d = S_HEADER;
          dout_d  = {HDR_TAG, frame_cnt_q};
          csum_d  = {HDR_TAG, frame_cnt_q};
          valid_d = 1'b1;
          pc_d    = PC_IN;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          state_d = S_PCW;
          dout_d  = pc_q;
        end
      end
      S_PCW: begin
        if (xfer) begin
          state_d = S_REGS;
          idx_d   = '0;
          dout_d  = RF_DATA;
          csum_d  = csum_q ^ dout_q;
        end
      end
      S_REGS: begin
        if (xfer) begin
          csum_d = csum_q ^ dout_q;
          if (idx_q == IW'(NUM_REGS - 1)) begin
            state_d = S_MEM;
            idx_d   = '0;
            dout_d  = DM_DATA;
          end else begin
            idx_d  = idx_q + 1'b1;
            dout_d = RF_DATA;
          end
        end
      end
      S_MEM: begin
        if (xfer) begin
          csum_d = csum_q ^ dout_q;
          if (idx_q == IW'(DM_WORDS - 1)) begin
            state_d = S_CSUM;
            dout_d  = csum_q ^ dout_q;
            last_d  = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            dout_d = DM_DATA;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          state_d     = S_IDLE;
          dout_d      = '0;
          valid_d     = 1'b0;
          last_d      = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    RF_ADDR = '0;
    DM_ADDR = '0;
    if (state_q == S_REGS) RF_ADDR = 5'(idx_q + 1'b1);
    if (state_q == S_MEM)  DM_ADDR = AW'(idx_q + 1'b1);
  end

  assign HALT_REQ   = (state_q != S_IDLE);
  assign BUSY       = (state_q != S_IDLE);
  assign DOUT       = dout_q;
  assign DOUT_VALID = valid_q;
  assign DOUT_LAST  = last_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb/tb_debug_dump_tx.sv - scoreboard bench for debug_dump_tx
module tb_debug_dump_tx;
  import debug_dump_tx_pkg::*;

  localparam int DMW = 32;
  localparam int FW  = frame_words(DMW);

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DUMP_START = 1'b0;
  logic [31:0] PC_IN = '0;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_DATA;
  logic [4:0]  DM_ADDR;
  logic [31:0] DM_DATA;
  logic        HALT_REQ, BUSY, DOUT_VALID, DOUT_LAST;
  logic [31:0] DOUT;
  logic        DOUT_READY = 1'b1;

  logic [31:0] rf [32];
  logic [31:0] dm [DMW];

  logic [32:0] exp_q[$];
  logic [15:0] model_cnt = '0;
  bit          bp_mode = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;
  int          words_seen = 0;

  debug_dump_tx #(.DM_WORDS(DMW)) dut (
    .CLK(CLK), .RESET(RESET), .DUMP_START(DUMP_START), .PC_IN(PC_IN),
    .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA), .DM_ADDR(DM_ADDR), .DM_DATA(DM_DATA),
    .HALT_REQ(HALT_REQ), .BUSY(BUSY), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST)
  );

  assign RF_DATA = rf[RF_ADDR];
  assign DM_DATA = dm[DM_ADDR];

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected frame built in software: header, PC, registers, memory, XOR checksum
  task automatic push_frame();
    logic [31:0] w;
    logic [31:0] cs;
    w  = {16'hD0D0, model_cnt};
    cs = w;
    exp_q.push_back({1'b0, w});
    exp_q.push_back({1'b0, PC_IN});
    cs ^= PC_IN;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({1'b0, rf[i]});
      cs ^= rf[i];
    end
    for (int i = 0; i < DMW; i++) begin
      exp_q.push_back({1'b0, dm[i]});
      cs ^= dm[i];
    end
    exp_q.push_back({1'b1, cs});
    model_cnt++;
  endtask

  task automatic start_frame();
    DUMP_START = 1'b1;
    @(posedge CLK); #1;
    DUMP_START = 1'b0;
    check("start_valid", 64'(DOUT_VALID), 64'd1);
    check("start_busy", 64'(BUSY), 64'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while ((DOUT_VALID || exp_q.size() != 0) && cyc < 3000);
    check("frame_done", 64'(cyc < 3000), 64'd1);
    check("idle_after_csum", 64'({HALT_REQ, BUSY, DOUT_VALID, DOUT_LAST}), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_dout"}, 64'(DOUT), 64'd0);
    check({name, "_ctl"}, 64'({DOUT_VALID, DOUT_LAST, HALT_REQ, BUSY}), 64'd0);
    check({name, "_addr"}, 64'({RF_ADDR, DM_ADDR}), 64'd0);
  endtask

  always begin
    @(posedge CLK); #1;
    DOUT_READY = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  // monitor: pops the scoreboard on every transfer and polices backpressure stability
  logic        stall_q = 1'b0;
  logic [31:0] stall_dout = '0;
  logic [32:0] e;
  always begin
    @(negedge CLK);
    if (RESET) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 64'(DOUT_VALID), 64'd1);
        check("stall_dout", 64'(DOUT), 64'(stall_dout));
      end
      if (DOUT_VALID) begin
        check("halt_req", 64'(HALT_REQ), 64'd1);
        check("busy", 64'(BUSY), 64'd1);
      end
      if (DOUT_VALID && DOUT_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %0h expected no transfer", DOUT);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("word%0d", words_seen), 64'({DOUT_LAST, DOUT}), 64'(e));
          words_seen++;
        end
      end
      stall_q    = DOUT_VALID && !DOUT_READY;
      stall_dout = DOUT;
    end
  end

  initial begin
    int c;
    int base;
    int guard;
    bit p5, p66;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < DMW; i++) dm[i] = '0;
    PC_IN = 32'h40;
    repeat (5) @(posedge CLK);
    #1;
    check_zero("reset");
    RESET = 1'b0;

    // all-zero state
    push_frame();
    start_frame();
    wait_done(c);
    check("len_zero", 64'(c), 64'(FW));

    // distinct contents
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    for (int i = 0; i < DMW; i++) dm[i] = 32'h100 + 32'(i);
    PC_IN = 32'h0040_1234;
    push_frame();
    start_frame();
    wait_done(c);
    check("len_content", 64'(c), 64'(FW));

    // 30% ready duty
    bp_mode = 1'b1;
    push_frame();
    start_frame();
    wait_done(c);
    bp_mode = 1'b0;
    @(posedge CLK); #1;

    // start pulses at words 5 and 66 must be ignored
    base = words_seen;
    push_frame();
    start_frame();
    p5 = 0; p66 = 0; guard = 0;
    while (DOUT_VALID && guard < 500) begin
      if (!p5 && words_seen - base == 5) begin DUMP_START = 1'b1; p5 = 1; end
      else if (!p66 && words_seen - base == 66) begin DUMP_START = 1'b1; p66 = 1; end
      else DUMP_START = 1'b0;
      @(posedge CLK); #1;
      guard++;
    end
    DUMP_START = 1'b0;
    check("busy_pulses_issued", 64'({p5, p66}), 64'b11);
    repeat (5) @(posedge CLK);
    #1;
    check("no_queued_frame", 64'({DOUT_VALID, BUSY}), 64'd0);
    push_frame();
    start_frame();
    wait_done(c);

    // reset mid-frame
    base = words_seen;
    push_frame();
    start_frame();
    guard = 0;
    while (words_seen - base < 20 && guard < 500) begin
      @(posedge CLK); #1;
      guard++;
    end
    RESET = 1'b1;
    @(posedge CLK); #1;
    exp_q.delete();
    check_zero("abort");
    RESET = 1'b0;
    model_cnt = '0;
    push_frame();
    start_frame();
    wait_done(c);

    // frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.frame_cnt_q;
    model_cnt = 16'hFFFF;
    push_frame();
    start_frame();
    wait_done(c);
    push_frame();
    start_frame();
    wait_done(c);

    repeat (3) @(posedge CLK);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
